// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM timer controller.
// Holds the default counter/prescaler widths, the PWM function encodings
// consumed by the downstream generator, and the controller state type.
package pwm_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int PSC_W_DEF = 8;

  typedef enum logic [1:0] {
    FN_ALIGN_LEFT  = 2'b00,
    FN_ALIGN_RIGHT = 2'b01,
    FN_RANGE       = 2'b10
  } pwm_fn_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } pwm_state_e;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler for the PWM timer.
// Counts 0..prescale while run is high and flags tick in the cycle the count
// reaches prescale. clr zeroes the count and suppresses tick.
// Ports: clk, rst_n (async, active-low), run, clr, prescale -> tick.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int PSC_W = PSC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             clr,
  input  logic [PSC_W-1:0] prescale,
  output logic             tick
);

  logic [PSC_W-1:0] psc_q, psc_d;
  logic             at_top;

  always_comb begin
    // >= rather than == so a prescale lowered below the held count cannot
    // leave the counter running all the way round its full range.
    at_top = (psc_q >= prescale);
    tick   = run && !clr && at_top;
    psc_d  = psc_q;
    if (clr) begin
      psc_d = '0;
    end else if (run) begin
      psc_d = at_top ? '0 : psc_q + PSC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_q <= '0;
    end else begin
      psc_q <= psc_d;
    end
  end

endmodule

// File: rtl/pwm_timer_ctrl.sv
// PWM timer controller: run/idle sequencing, prescaled period counter with
// wrap pulse, and double-buffered configuration (staging -> active).
// Ports:
//   clk, rst_n (async, active-low), en, cnt_clr, prescale
//   cfg_wr, cfg_period, cfg_compare1, cfg_compare2, cfg_functions, cfg_pwm_en
//   count_val, period, compare1, compare2, functions, pwm_en, ovf, upd_pending
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | counter frozen, ovf low, staging copied to active every cycle
// ST_RUN  | prescaler ticks advance count_val; staging copied on wrap
module pwm_timer_ctrl
  import pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int PSC_W = PSC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cnt_clr,
  input  logic [PSC_W-1:0] prescale,
  input  logic             cfg_wr,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_compare1,
  input  logic [CNT_W-1:0] cfg_compare2,
  input  logic [1:0]       cfg_functions,
  input  logic             cfg_pwm_en,
  output logic [CNT_W-1:0] count_val,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] compare1,
  output logic [CNT_W-1:0] compare2,
  output logic [1:0]       functions,
  output logic             pwm_en,
  output logic             ovf,
  output logic             upd_pending
);

  pwm_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             pend_q, pend_d;
  logic             pwm_en_q, pwm_en_d;

  logic [CNT_W-1:0] stg_per_q, stg_per_d, stg_cmp1_q, stg_cmp1_d, stg_cmp2_q, stg_cmp2_d;
  logic [1:0]       stg_fn_q, stg_fn_d;
  logic             stg_en_q, stg_en_d;

  logic [CNT_W-1:0] act_per_q, act_per_d, act_cmp1_q, act_cmp1_d, act_cmp2_q, act_cmp2_d;
  logic [1:0]       act_fn_q, act_fn_d;
  logic             act_en_q, act_en_d;

  logic run, tick, at_end, wrap, copy;

  assign run = (state_q == ST_RUN);

  pwm_prescaler #(.PSC_W(PSC_W)) u_psc (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .clr      (cnt_clr),
    .prescale (prescale),
    .tick     (tick)
  );

  always_comb begin
    state_d = en ? ST_RUN : ST_IDLE;

    // Period 0 or 1 degenerates to "wrap on every tick"; guard before the
    // subtraction so period 0 cannot underflow.
    at_end = (act_per_q <= CNT_W'(1)) || (cnt_q >= act_per_q - CNT_W'(1));
    wrap   = tick && at_end;
    copy   = wrap || !run || cnt_clr;

    cnt_d = cnt_q;
    ovf_d = 1'b0;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (tick) begin
      if (at_end) begin
        cnt_d = '0;
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    stg_per_d  = stg_per_q;
    stg_cmp1_d = stg_cmp1_q;
    stg_cmp2_d = stg_cmp2_q;
    stg_fn_d   = stg_fn_q;
    stg_en_d   = stg_en_q;
    act_per_d  = act_per_q;
    act_cmp1_d = act_cmp1_q;
    act_cmp2_d = act_cmp2_q;
    act_fn_d   = act_fn_q;
    act_en_d   = act_en_q;
    pend_d     = pend_q;

    if (copy) begin
      act_per_d  = stg_per_q;
      act_cmp1_d = stg_cmp1_q;
      act_cmp2_d = stg_cmp2_q;
      act_fn_d   = stg_fn_q;
      act_en_d   = stg_en_q;
      pend_d     = 1'b0;
    end
    // A write landing on a copy event goes to staging after the old staging
    // has moved to active, so it stays pending for the next copy.
    if (cfg_wr) begin
      stg_per_d  = cfg_period;
      stg_cmp1_d = cfg_compare1;
      stg_cmp2_d = cfg_compare2;
      stg_fn_d   = cfg_functions;
      stg_en_d   = cfg_pwm_en;
      pend_d     = 1'b1;
    end

    pwm_en_d = act_en_d && (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      pend_q     <= 1'b0;
      pwm_en_q   <= 1'b0;
      stg_per_q  <= '0;
      stg_cmp1_q <= '0;
      stg_cmp2_q <= '0;
      stg_fn_q   <= '0;
      stg_en_q   <= 1'b0;
      act_per_q  <= '0;
      act_cmp1_q <= '0;
      act_cmp2_q <= '0;
      act_fn_q   <= '0;
      act_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      pend_q     <= pend_d;
      pwm_en_q   <= pwm_en_d;
      stg_per_q  <= stg_per_d;
      stg_cmp1_q <= stg_cmp1_d;
      stg_cmp2_q <= stg_cmp2_d;
      stg_fn_q   <= stg_fn_d;
      stg_en_q   <= stg_en_d;
      act_per_q  <= act_per_d;
      act_cmp1_q <= act_cmp1_d;
      act_cmp2_q <= act_cmp2_d;
      act_fn_q   <= act_fn_d;
      act_en_q   <= act_en_d;
    end
  end

  assign count_val   = cnt_q;
  assign period      = act_per_q;
  assign compare1    = act_cmp1_q;
  assign compare2    = act_cmp2_q;
  assign functions   = act_fn_q;
  assign pwm_en      = pwm_en_q;
  assign ovf         = ovf_q;
  assign upd_pending = pend_q;

endmodule

// File: doc/pwm_timer_ctrl.md
PWM_TIMER_CTRL -- requirements
Module: pwm_timer_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, meaning counter/period/compare width.
REQ-002 SHALL have parameter PSC_W, default 8, meaning prescaler width.
REQ-003 SHALL have ports: clk  in  1  peripheral clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: en  in  1  counter run enable; cnt_clr  in  1  synchronous counter clear pulse.
REQ-005 SHALL have ports: prescale  in  PSC_W  tick divider (tick every prescale+1 clocks).
REQ-006 SHALL have ports: cfg_wr  in  1  config write strobe; cfg_period, cfg_compare1, cfg_compare2  in  CNT_W  staged values; cfg_functions  in  2  staged mode; cfg_pwm_en  in  1  staged output enable.
REQ-007 SHALL have ports: count_val  out  CNT_W  current count; period, compare1, compare2  out  CNT_W  active values; functions  out  2  active mode; pwm_en  out  1  active enable to generator.
REQ-008 SHALL have ports: ovf  out  1  one-cycle wrap pulse; upd_pending  out  1  staged config not yet active.

Function
REQ-009 SHALL implement states IDLE (en=0) and RUN (en=1); IDLE->RUN when en=1, RUN->IDLE when en=0, each taking effect on the next clk edge.
REQ-010 SHALL, in RUN, count the prescaler 0..prescale and assert internal tick in the cycle prescaler==prescale, prescaler then returning to 0; prescale=0 gives tick every cycle.
REQ-011 SHALL, on tick, set count_val to count_val+1, or to 0 with ovf=1 when count_val >= period-1 (wrap).
REQ-012 SHALL, when active period <= 1, hold count_val at 0 and pulse ovf on every tick.
REQ-013 SHALL, in IDLE, hold prescaler and count_val unchanged and keep ovf=0.
REQ-014 SHALL, on cfg_wr, capture all cfg_* inputs into staging registers and set upd_pending=1 in the next cycle.
REQ-015 SHALL copy staging into active outputs (period, compare1, compare2, functions, pwm_en source) and clear upd_pending at a wrap cycle, or in any IDLE cycle, or on cnt_clr.
REQ-016 SHALL, when cfg_wr coincides with a copy event, load the previous staging into active, capture the new cfg_* into staging, and leave upd_pending=1.
REQ-017 SHALL, on cnt_clr, zero prescaler and count_val in the next cycle without asserting ovf; cnt_clr dominates tick in the same cycle.
REQ-018 SHALL drive pwm_en = active pwm_en AND (state==RUN), registered.
REQ-019 SHALL register every output; count_val and active values change only on clk edges.
REQ-020 SHALL treat compare values as pass-through; no range checks on compare1/compare2.

Reset
REQ-021 SHALL, on rst_n low, asynchronously clear state to IDLE and clear prescaler, count_val, staging, active registers, ovf, upd_pending and pwm_en to 0.
REQ-022 SHALL, on reset assertion mid-count, discard any pending update; after release, resume only when en=1.

Structure
REQ-023 SHALL place function encodings (align-left 00, align-right 01, range-between-compares 10) and default CNT_W/PSC_W in shared package pwm_pkg.
REQ-024 SHALL instantiate one sub-module pwm_prescaler (counter plus tick output, inputs clk, rst_n, run, clr, prescale).

Verification
REQ-025 SHALL cover: prescale=0, period=4, en=1 -> count_val 0,1,2,3,0; ovf high in cycle count_val 3->0.
REQ-026 SHALL cover: prescale=2, period=3 -> count_val advances every 3 clocks; ovf every 9 clocks.
REQ-027 SHALL cover: running period=10, cfg_wr period=5 at count 2 -> upd_pending=1 until wrap at 9, then period=5 and next wrap at 4.
REQ-028 SHALL cover: cfg_wr on the wrap cycle -> old staging applied, upd_pending stays 1, new value applied at following wrap.
REQ-029 SHALL cover: period=1 and period=0 -> count_val stays 0, ovf every tick; cnt_clr at count 7 -> count_val 0 next cycle, no ovf.
REQ-030 SHALL cover: rst_n low at count 6 with upd_pending=1 -> all outputs 0 immediately, upd_pending 0, IDLE after release.
